// File: rtl/pc_update_unit.sv
// PC stage feeding adder16bit: operand selection, next-PC mux, link capture, BOOT/RUN/HALTED.
// Optional PC history buffer enabled by defining PC_HISTORY_EN.
module pc_update_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] INC          = 16'd2,
  parameter int unsigned HIST_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          pc_write,
  input  logic [1:0]                    pc_src,
  input  logic                          branch_cond,
  input  logic [15:0]                   imm_offset,
  input  logic [11:0]                   jump_target,
  input  logic [15:0]                   reg_target,
  input  logic                          link,
  input  logic                          halt,
  input  logic [15:0]                   adder_sum,
  output logic [15:0]                   adder_a,
  output logic [15:0]                   adder_b,
  output logic [15:0]                   pc,
  output logic [15:0]                   ra,
  output logic                          halted,
  output logic                          pc_changed,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [15:0]                   hist_pc
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_q;
  logic [15:0] pc_q;
  logic [15:0] ra_q;
  logic        pc_changed_q;
  logic        taken;
  logic        accept;
  logic [15:0] next_pc;

  always_comb begin
    taken   = (pc_src == 2'b01) && branch_cond;
    adder_a = pc_q;
    adder_b = taken ? {imm_offset[14:0], 1'b0} : INC;
    // halt wins over a simultaneous pc_write
    accept  = (state_q == RUN) && pc_write && !halt;
    next_pc = adder_sum;
    unique case (pc_src)
      2'b00, 2'b01: next_pc = adder_sum;
      2'b10:        next_pc = {pc_q[15:13], jump_target, 1'b0};
      2'b11:        next_pc = {reg_target[15:1], 1'b0};
      default:      next_pc = adder_sum;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      ra_q         <= 16'h0000;
      pc_changed_q <= 1'b0;
    end else begin
      pc_changed_q <= accept;
      if (accept) begin
        pc_q <= next_pc;
        if (link && !taken) ra_q <= adder_sum;
      end
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc         = pc_q;
  assign ra         = ra_q;
  assign halted     = (state_q == HALTED);
  assign pc_changed = pc_changed_q;

  logic unused_bits;
  assign unused_bits = reg_target[0];

`ifdef PC_HISTORY_EN
  localparam int unsigned HW = $clog2(HIST_DEPTH);

  logic [15:0]   hist_q [HIST_DEPTH];
  logic [HW-1:0] wrptr_q;
  logic [HW-1:0] rd_ptr;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wrptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 16'h0000;
    end else if (accept) begin
      hist_q[wrptr_q] <= pc_q;
      wrptr_q         <= wrptr_q + HW'(1);
    end
  end

  // Pointer width equals log2(depth), so the subtraction wraps modulo HIST_DEPTH.
  assign rd_ptr  = wrptr_q - HW'(1) - hist_idx;
  assign hist_pc = hist_q[rd_ptr];
`else
  logic unused_hist;
  assign unused_hist = ^hist_idx;
  assign hist_pc     = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed vectors, a behavioural model checked every cycle,
// and literal expectations from hand-computed scenarios.
module tb_pc_update_unit;

  localparam logic [15:0] RV  = 16'h0000;
  localparam logic [15:0] INC = 16'd2;
  localparam int unsigned HD  = 4;

  logic                  CLK = 1'b0;
  logic                  Reset, pc_write, branch_cond, link, halt;
  logic [1:0]            pc_src;
  logic [15:0]           imm_offset, reg_target, adder_sum;
  logic [11:0]           jump_target;
  logic [15:0]           adder_a, adder_b, pc, ra, hist_pc;
  logic                  halted, pc_changed;
  logic [$clog2(HD)-1:0] hist_idx;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  pc_update_unit #(
    .RESET_VECTOR(RV),
    .INC         (INC),
    .HIST_DEPTH  (HD)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .branch_cond(branch_cond),
    .imm_offset (imm_offset),
    .jump_target(jump_target),
    .reg_target (reg_target),
    .link       (link),
    .halt       (halt),
    .adder_sum  (adder_sum),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .pc         (pc),
    .ra         (ra),
    .halted     (halted),
    .pc_changed (pc_changed),
    .hist_idx   (hist_idx),
    .hist_pc    (hist_pc)
  );

  // Stand-in for the combinational adder16bit.
  assign adder_sum = adder_a + adder_b;

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_ra;
  logic        m_halted, m_boot, m_chg;
  logic [15:0] hq[$];

  function automatic logic [15:0] target(input logic [15:0] cur, input logic [1:0] src,
                                         input logic bc, input logic [15:0] imm,
                                         input logic [11:0] jt, input logic [15:0] rt);
    case (src)
      2'd0:    return cur + INC;
      2'd1:    return bc ? cur + imm * 16'd2 : cur + INC;
      2'd2:    return (cur & 16'hE000) + {4'h0, jt} * 16'd2;
      default: return rt & 16'hFFFE;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (Reset) begin
      m_pc <= RV; m_ra <= 16'h0; m_halted <= 1'b0; m_boot <= 1'b1; m_chg <= 1'b0;
      hq.delete();
    end else if (m_halted) begin
      m_chg <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_chg <= 1'b0;
    end else if (halt) begin
      m_halted <= 1'b1; m_chg <= 1'b0;
    end else if (pc_write) begin
      m_pc  <= target(m_pc, pc_src, branch_cond, imm_offset, jump_target, reg_target);
      if (link && !(pc_src == 2'd1 && branch_cond)) m_ra <= m_pc + INC;
      m_chg <= 1'b1;
      hq.push_back(m_pc);
      if (hq.size() > HD) void'(hq.pop_front());
    end else begin
      m_chg <= 1'b0;
    end
  end

  // Every-cycle comparison, mid-cycle when inputs and outputs are stable.
  always @(negedge CLK) begin
    if (checking) begin
      chk("pc", pc, m_pc);
      chk("ra", ra, m_ra);
      chk("halted", {15'h0, halted}, {15'h0, m_halted});
      chk("pc_changed", {15'h0, pc_changed}, {15'h0, m_chg});
      chk("adder_a", adder_a, m_pc);
      chk("adder_b", adder_b,
          (pc_src == 2'd1 && branch_cond) ? imm_offset * 16'd2 : INC);
`ifdef PC_HISTORY_EN
      chk("hist_pc", hist_pc,
          (int'(hist_idx) < hq.size()) ? hq[hq.size() - 1 - int'(hist_idx)] : 16'h0);
`else
      chk("hist_pc", hist_pc, 16'h0000);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_src = 2'd3; reg_target = v; pc_write = 1'b1; link = 1'b0; branch_cond = 1'b0;
    step();
    chk("set_pc", pc, v & 16'hFFFE);
  endtask

  initial begin
    Reset = 1'b1; pc_write = 1'b0; pc_src = 2'd0; branch_cond = 1'b0; link = 1'b0;
    halt = 1'b0; imm_offset = 16'h0; jump_target = 12'h0; reg_target = 16'h0; hist_idx = '0;
    step();
    checking = 1'b1;
    step();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_ra", ra, 16'h0000);
    chk("reset_halted", {15'h0, halted}, 16'h0);
    chk("reset_changed", {15'h0, pc_changed}, 16'h0);

    // Boot cycle ignores pc_write, then increments.
    Reset = 1'b0; pc_write = 1'b1; pc_src = 2'd0;
    step(); chk("boot_pc", pc, 16'h0000); chk("boot_changed", {15'h0, pc_changed}, 16'h0);
    step(); chk("inc1", pc, 16'h0002); chk("inc1_changed", {15'h0, pc_changed}, 16'h1);
    step(); chk("inc2", pc, 16'h0004);
    step(); chk("inc3", pc, 16'h0006);
    pc_write = 1'b0;
    step(); chk("hold_pc", pc, 16'h0006); chk("hold_changed", {15'h0, pc_changed}, 16'h0);

    set_pc(16'h0010);
    pc_src = 2'd1; imm_offset = 16'hFFFD; branch_cond = 1'b1;
    #1 chk("br_adder_b", adder_b, 16'hFFFA);
    step(); chk("br_taken", pc, 16'h000A);
    set_pc(16'h0010);
    pc_src = 2'd1; branch_cond = 1'b0;
    #1 chk("nbr_adder_b", adder_b, 16'h0002);
    step(); chk("br_not_taken", pc, 16'h0012);

    set_pc(16'h2004);
    pc_src = 2'd2; jump_target = 12'h123; link = 1'b1;
    step(); chk("jump_pc", pc, 16'h2246); chk("jump_ra", ra, 16'h2006);
    link = 1'b0;

    set_pc(16'hFFFE);
    pc_src = 2'd0;
    step(); chk("wrap_pc", pc, 16'h0000);
    pc_src = 2'd3; reg_target = 16'h1235;
    step(); chk("reg_pc", pc, 16'h1234);

    // Link ignored on a taken branch.
    pc_src = 2'd1; imm_offset = 16'h0004; branch_cond = 1'b1; link = 1'b1;
    step(); chk("br_link_pc", pc, 16'h123C); chk("br_link_ra", ra, 16'h2006);
    link = 1'b0; branch_cond = 1'b0;

    // Same-value update still pulses pc_changed.
    pc_src = 2'd3; reg_target = 16'h123C;
    step(); chk("same_pc_changed", {15'h0, pc_changed}, 16'h1);

    pc_src = 2'd0; halt = 1'b1; pc_write = 1'b1;
    step(); chk("halt_pc", pc, 16'h123C); chk("halt_flag", {15'h0, halted}, 16'h1);
    halt = 1'b0;
    step(); step(); chk("halted_frozen", pc, 16'h123C);

    Reset = 1'b1;
    step(); chk("rst_halted_pc", pc, RV); chk("rst_halted_flag", {15'h0, halted}, 16'h0);

    // Halt during boot is ignored.
    Reset = 1'b0; halt = 1'b1;
    step(); chk("boot_halt_ignored", {15'h0, halted}, 16'h0);
    step(); chk("run_halt", {15'h0, halted}, 16'h1);
    halt = 1'b0; Reset = 1'b1;
    step();

    Reset = 1'b0; pc_write = 1'b1; pc_src = 2'd0;
    step(); step(); step();
    chk("hist_seq_pc", pc, 16'h0004);
`ifdef PC_HISTORY_EN
    hist_idx = 2'd0; #1 chk("hist0", hist_pc, 16'h0002);
    hist_idx = 2'd1; #1 chk("hist1", hist_pc, 16'h0000);
`endif
    for (int i = 0; i < 7; i++) begin
      hist_idx = 2'(i % HD);
      step();
    end

    pc_write = 1'b0;
    step();
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
Program-counter stage that sits directly upstream of adder16bit and also consumes its result. Holds the 16-bit PC and drives the adder operands: PC plus 2, or PC plus a branch offset. On a write strobe it latches the adder sum, an absolute jump target or a register target as the next PC. It also captures the link (return) address and implements the boot and halt sequencing of the multicycle datapath.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset
INC, 16'd2, byte increment per instruction (16-bit instructions)
HIST_DEPTH, 4, entries in PC history buffer; used only with PC_HISTORY_EN; power of 2

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
pc_write  in  1  update PC at this edge
pc_src  in  2  00 increment, 01 branch-relative, 10 jump-absolute, 11 register
branch_cond  in  1  branch taken (meaningful only when pc_src=01)
imm_offset  in  16  sign-extended word offset for branches
jump_target  in  12  absolute word target field
reg_target  in  16  register-indirect target
link  in  1  capture return address on this pc_write
halt  in  1  enter HALTED
adder_sum  in  16  result returned from adder16bit
adder_a  out  16  adder operand A
adder_b  out  16  adder operand B
pc  out  16  current PC
ra  out  16  link register
halted  out  1  high in HALTED
pc_changed  out  1  one-cycle pulse after any PC update
hist_idx  in  log2(HIST_DEPTH)  history read index (PC_HISTORY_EN only)
hist_pc  out  16  history read data (PC_HISTORY_EN only)

Behaviour:
- Clocking: single clock CLK; Reset is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset, from any state and any cycle: pc=RESET_VECTOR, ra=0, halted=0, pc_changed=0, state=BOOT. Reset overrides every other input.
- adder_a = pc, always, combinationally.
- adder_b = imm_offset<<1 (low 16 bits, modulo 2^16) when pc_src=01 and branch_cond=1; otherwise INC. Combinational.
- Because the adder is combinational, adder_sum is valid in the same cycle.
- Next-PC selection, applied at the edge when the update condition holds:
  - pc_src 00 or 01: pc <= adder_sum.
  - pc_src 10: pc <= {pc[15:13], jump_target, 1'b0}.
  - pc_src 11: pc <= {reg_target[15:1], 1'b0}.
- Link: if link=1 on an accepted pc_write, ra <= adder_sum (pc+INC, since adder_b=INC for pc_src 00/10/11). For pc_src=01 with the branch taken, link is ignored.
- Arithmetic wraps modulo 2^16; there is no overflow flag.
- FSM states BOOT, RUN, HALTED:
  - BOOT: lasts exactly 1 cycle; pc_write and halt are ignored; then -> RUN.
  - RUN: pc_write is accepted. If halt=1, go to HALTED and do not update pc, even if pc_write=1 (halt has priority).
  - HALTED: pc and ra frozen, halted=1, all inputs ignored; exit only via Reset.
- pc_changed is registered: 1 for the cycle after an accepted pc_write, 0 otherwise. It is asserted even when the new PC equals the old one.

Optional Feature:
Macro PC_HISTORY_EN.
- Defined: a HIST_DEPTH-entry circular buffer records the old pc on every accepted pc_write, with a write pointer that wraps. hist_pc = entry at (wrptr-1-hist_idx) mod HIST_DEPTH; hist_idx=0 returns the most recent old PC. Reset clears all entries and the pointer to 0.
- Undefined: no buffer is built; hist_pc is tied to 16'h0000 and hist_idx is unused.

Test Plan:
- Reset held 2 cycles, then released with pc_write=1 -> pc=0x0000 through the BOOT cycle; first increment to 0x0002 occurs one cycle after BOOT; halted=0.
- RUN with pc_src=00, three consecutive pc_write -> pc 0x0000->0x0002->0x0004->0x0006; pc_changed high in each following cycle.
- pc=0x0010, pc_src=01, imm_offset=0xFFFD, branch_cond=1 -> adder_b=0xFFFA, pc=0x000A; same with branch_cond=0 -> pc=0x0012.
- pc=0x2004, pc_src=10, jump_target=0x123, link=1 -> pc=0x2246, ra=0x2006.
- pc=0xFFFE, pc_src=00 -> pc=0x0000 (wrap); pc_src=11, reg_target=0x1235 -> pc=0x1234.
- halt=1 together with pc_write=1 -> pc unchanged, halted=1, further pc_write ignored. Reset while HALTED -> pc=RESET_VECTOR, state BOOT. With PC_HISTORY_EN: after PCs 0->2->4, hist_idx=0 gives 0x0002 and hist_idx=1 gives 0x0000.
